// File: rtl/decommutator.sv
// Serial-to-parallel frame decommutator: gathers PHASES samples per frame and flags short frames.
// Define DECOMMUTATOR_OCLK_EN to generate the divided frame-rate clock on o_clk; otherwise o_clk is 0.
module decommutator #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned PHASES     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ena,
  input  logic                         i_sof,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic [PHASES*DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_clk,
  output logic                         o_err
);

  localparam int unsigned CNT_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned FRAME_W = PHASES * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(PHASES - 1);

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   phase_c;
  logic [FRAME_W-1:0] asm_q;
  logic [FRAME_W-1:0] asm_d;
  logic [FRAME_W-1:0] data_d;
  logic               valid_d;
  logic               err_d;

  // Next-state: a qualified sof forces phase 0; the last phase publishes the frame.
  always_comb begin
    phase_c = cnt_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = o_data;
    valid_d = 1'b0;
    err_d   = o_err;
    if (i_ena) begin
      if (i_sof) begin
        phase_c = '0;
        if (cnt_q != '0) begin
          err_d = 1'b1;
        end
      end
      for (int unsigned p = 0; p < PHASES; p++) begin
        if (phase_c == CNT_W'(p)) begin
          asm_d[(PHASES-p)*DATA_WIDTH-1 -: DATA_WIDTH] = i_data;
        end
      end
      cnt_d = phase_c + CNT_W'(1);
      if (phase_c == LAST_PHASE) begin
        data_d  = asm_d;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      o_data  <= data_d;
      o_valid <= valid_d;
      o_err   <= err_d;
    end
  end

`ifdef DECOMMUTATOR_OCLK_EN
  logic oclk_d;

  // High for the second half of the phase sequence: 50% duty at i_clk/PHASES.
  always_comb begin
    oclk_d = (cnt_d >= CNT_W'(PHASES / 2));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_clk <= 1'b0;
    end else begin
      o_clk <= oclk_d;
    end
  end
`else
  assign o_clk = 1'b0;
`endif

endmodule

// File: tb/tb_decommutator.sv
// Randomized bench for decommutator against a queue-based frame model, plus directed frame scenarios.
module tb_decommutator;

  localparam int unsigned DW = 4;
  localparam int unsigned PH = 4;
  localparam int unsigned FW = DW * PH;

  logic          i_clk;
  logic          i_rst;
  logic          i_ena;
  logic          i_sof;
  logic [DW-1:0] i_data;
  logic [FW-1:0] o_data;
  logic          o_valid;
  logic          o_clk;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] frame_q[$];
  logic [FW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_err;
  logic          exp_clk;

  decommutator #(.DATA_WIDTH(DW), .PHASES(PH)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_ena  (i_ena),
    .i_sof  (i_sof),
    .i_data (i_data),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_clk  (o_clk),
    .o_err  (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare all outputs just after the edge.
  task automatic step(input logic rst, input logic ena, input logic sof, input logic [DW-1:0] d);
    i_rst  = rst;
    i_ena  = ena;
    i_sof  = sof;
    i_data = d;
    @(posedge i_clk);
    exp_valid = 1'b0;
    if (rst) begin
      frame_q.delete();
      exp_data = '0;
      exp_err  = 1'b0;
    end else if (ena) begin
      if (sof) begin
        if (frame_q.size() != 0) exp_err = 1'b1;
        frame_q.delete();
      end
      frame_q.push_back(d);
      if (frame_q.size() == PH) begin
        exp_data = '0;
        foreach (frame_q[i]) exp_data = (exp_data << DW) | FW'(frame_q[i]);
        exp_valid = 1'b1;
        frame_q.delete();
      end
    end
`ifdef DECOMMUTATOR_OCLK_EN
    exp_clk = (frame_q.size() >= PH / 2);
`else
    exp_clk = 1'b0;
`endif
    #1;
    check("o_valid", 64'(o_valid), 64'(exp_valid));
    check("o_data",  64'(o_data),  64'(exp_data));
    check("o_err",   64'(o_err),   64'(exp_err));
    check("o_clk",   64'(o_clk),   64'(exp_clk));
    @(negedge i_clk);
  endtask

  initial begin
    i_rst = 1'b1; i_ena = 1'b0; i_sof = 1'b0; i_data = '0;
    exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_clk = 1'b0;
    @(negedge i_clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 4'h9);
    check("rst_data", 64'(o_data), 64'h0);

    // Single frame, then back-to-back frame
    step(1'b0, 1'b1, 1'b1, 4'hA);
    step(1'b0, 1'b1, 1'b0, 4'hB);
    step(1'b0, 1'b1, 1'b0, 4'hC);
    step(1'b0, 1'b1, 1'b0, 4'hD);
    check("abcd_data", 64'(o_data), 64'hABCD);
    check("abcd_valid", 64'(o_valid), 64'h1);
    step(1'b0, 1'b1, 1'b1, 4'h1);
    check("valid_pulse", 64'(o_valid), 64'h0);
    step(1'b0, 1'b1, 1'b0, 4'h2);
    step(1'b0, 1'b1, 1'b0, 4'h3);
    step(1'b0, 1'b1, 1'b0, 4'h4);
    check("b2b_data", 64'(o_data), 64'h1234);

    // Enable gap mid-frame, sof ignored while disabled
    step(1'b0, 1'b1, 1'b1, 4'hA);
    step(1'b0, 1'b1, 1'b0, 4'hB);
    step(1'b0, 1'b0, 1'b1, 4'h7);
    step(1'b0, 1'b0, 1'b0, 4'h7);
    step(1'b0, 1'b0, 1'b0, 4'h7);
    step(1'b0, 1'b1, 1'b0, 4'hC);
    check("gap_hold", 64'(o_data), 64'h1234);
    step(1'b0, 1'b1, 1'b0, 4'hD);
    check("gap_data", 64'(o_data), 64'hABCD);

    // Short frame then a full frame: sticky error
    step(1'b0, 1'b1, 1'b1, 4'h5);
    step(1'b0, 1'b1, 1'b0, 4'h6);
    step(1'b0, 1'b1, 1'b0, 4'h7);
    step(1'b0, 1'b1, 1'b1, 4'h1);
    check("short_err", 64'(o_err), 64'h1);
    step(1'b0, 1'b1, 1'b0, 4'h2);
    step(1'b0, 1'b1, 1'b0, 4'h3);
    step(1'b0, 1'b1, 1'b0, 4'h4);
    check("short_data", 64'(o_data), 64'h1234);

    // Reset mid-frame
    step(1'b0, 1'b1, 1'b1, 4'hA);
    step(1'b0, 1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b1, 1'b0, 4'hC);
    check("midrst_err", 64'(o_err), 64'h0);
    step(1'b0, 1'b1, 1'b0, 4'h1);
    step(1'b0, 1'b1, 1'b0, 4'h2);
    step(1'b0, 1'b1, 1'b0, 4'h3);
    step(1'b0, 1'b1, 1'b0, 4'h4);
    check("midrst_data", 64'(o_data), 64'h1234);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, e, s;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = (frame_q.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      step(r, e, s, DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
